// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit with word-granular memory port and misaligned split
//
// Purpose: accepts one byte/half/word load or store at a time from the core,
// splits accesses that straddle a word boundary into two word accesses, uses
// read-modify-write for sub-word stores and extends load data.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i, wr_i, funct3_i  request strobe, store/load select, RISC-V access type
//   addr_i, wr_data_i      byte address, right-aligned store data
//   busy_o, done_o, fault_o, rd_data_o   status and extended load result
//   mem_addr_o, mem_op_o, mem_data_in_o, mem_wr_en_o, mem_data_out_i
//                          word-wide data memory port (read data one cycle late)
module mem_lsu #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [31:0] rd_data_o,
    output logic [31:0] mem_addr_o,
    output logic [2:0]  mem_op_o,
    output logic [31:0] mem_data_in_o,
    output logic        mem_wr_en_o,
    input  logic [31:0] mem_data_out_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_R0, S_C0, S_W0, S_R1, S_C1, S_W1, S_RESP
    } state_e;

    state_e      state_q, state_d;

    logic        wr_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wr_data_q;
    logic [31:0] word0_q;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;
    logic        mem_wr_en_q, mem_wr_en_d;

    // The request fields seen by the datapath: live inputs while idle (so the
    // accepting edge can already act on them), the registered copy afterwards.
    logic        accept;
    logic        wr_e;
    logic [2:0]  funct3_e;
    logic [31:0] addr_e;
    logic [31:0] wr_data_e;

    assign accept    = (state_q == S_IDLE) && req_i;
    assign wr_e      = (state_q == S_IDLE) ? wr_i      : wr_q;
    assign funct3_e  = (state_q == S_IDLE) ? funct3_i  : funct3_q;
    assign addr_e    = (state_q == S_IDLE) ? addr_i    : addr_q;
    assign wr_data_e = (state_q == S_IDLE) ? wr_data_i : wr_data_q;

    logic [1:0]  offset;
    logic [2:0]  size;
    logic        span;
    logic        misaligned;
    logic        funct3_bad;
    logic        illegal;
    logic [31:0] a0;
    logic [31:0] a1;

    assign offset = addr_e[1:0];

    always_comb begin
        case (funct3_e[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
    end

    // offset (max 3) + size (max 4) fits in three bits.
    assign span = (({1'b0, offset} + size) > 3'd4);

    always_comb begin
        case (size)
            3'd1:    misaligned = 1'b0;
            3'd2:    misaligned = offset[0];
            default: misaligned = (offset != 2'b00);
        endcase
    end

    assign funct3_bad = wr_e ? (funct3_e[2] || (funct3_e[1:0] == 2'b11))
                             : ((funct3_e == 3'b011) || (funct3_e[2:1] == 2'b11));
    assign illegal    = funct3_bad || (!ALLOW_MISALIGNED && misaligned);

    assign a0 = {addr_e[31:2], 2'b00};
    assign a1 = a0 + 32'd4;

    // Word0 arrives from memory during C0 (non-span) or R1 (span load); in
    // those cycles it is taken straight from the bus, otherwise from word0_q.
    // Word1 is only ever needed in C1, where it is on the bus.
    logic [31:0] word0_e;
    logic [63:0] pair;
    logic [63:0] size_mask;
    logic [5:0]  shamt;
    logic [63:0] lane_mask;
    logic [63:0] merged;
    logic [31:0] ld_word;
    logic [31:0] ld_result;

    assign word0_e = ((state_q == S_C0) || (state_q == S_R1)) ? mem_data_out_i : word0_q;
    assign pair    = {mem_data_out_i, word0_e};

    always_comb begin
        case (size)
            3'd1:    size_mask = 64'h0000_0000_0000_00FF;
            3'd2:    size_mask = 64'h0000_0000_0000_FFFF;
            default: size_mask = 64'h0000_0000_FFFF_FFFF;
        endcase
    end

    assign shamt     = {1'b0, offset, 3'b000};
    assign lane_mask = size_mask << shamt;
    assign merged    = (pair & ~lane_mask) | (({32'h0, wr_data_e} & size_mask) << shamt);
    assign ld_word   = 32'(pair >> shamt);

    always_comb begin
        case (funct3_e)
            3'b000:  ld_result = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_result = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_result = {24'h0, ld_word[7:0]};
            3'b101:  ld_result = {16'h0, ld_word[15:0]};
            default: ld_result = ld_word;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            wr_q          <= 1'b0;
            funct3_q      <= 3'b000;
            addr_q        <= 32'h0;
            wr_data_q     <= 32'h0;
            word0_q       <= 32'h0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            rd_data_q     <= 32'h0;
            mem_addr_q    <= 32'h0;
            mem_data_in_q <= 32'h0;
            mem_wr_en_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q      <= wr_i;
                funct3_q  <= funct3_i;
                addr_q    <= addr_i;
                wr_data_q <= wr_data_i;
            end
            if ((state_q == S_C0) || (state_q == S_R1)) begin
                word0_q <= mem_data_out_i;
            end
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            rd_data_q     <= rd_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_wr_en_q   <= mem_wr_en_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (illegal) begin
                        state_d = S_RESP;
                    end else if (wr_e && (funct3_e == 3'b010) && (offset == 2'b00)) begin
                        state_d = S_W0;
                    end else begin
                        state_d = S_R0;
                    end
                end
            end
            S_R0:    state_d = (!wr_e && span) ? S_R1 : S_C0;
            S_C0:    state_d = wr_e ? S_W0 : S_RESP;
            S_W0:    state_d = span ? S_R1 : S_RESP;
            S_R1:    state_d = S_C1;
            S_C1:    state_d = wr_e ? S_W1 : S_RESP;
            S_W1:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered; their next values follow the state being entered.
    always_comb begin
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_RESP);
        fault_d       = (state_d == S_RESP) && illegal;
        mem_wr_en_d   = (state_d == S_W0) || (state_d == S_W1);
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        rd_data_d     = rd_data_q;
        case (state_d)
            S_R0, S_W0: mem_addr_d = a0;
            S_R1, S_W1: mem_addr_d = a1;
            default:    mem_addr_d = mem_addr_q;
        endcase
        if (state_d == S_W0) begin
            mem_data_in_d = merged[31:0];
        end else if (state_d == S_W1) begin
            mem_data_in_d = merged[63:32];
        end
        if ((state_d == S_RESP) && !illegal && !wr_e) begin
            rd_data_d = ld_result;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign fault_o       = fault_q;
    assign rd_data_o     = rd_data_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_op_o      = 3'b010;
    assign mem_data_in_o = mem_data_in_q;
    assign mem_wr_en_o   = mem_wr_en_q;

endmodule
